// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, width helpers and state encoding for systolic_feeder
package systolic_pkg;

  localparam int DEF_IN_WORD_SIZE  = 8;
  localparam int DEF_NUM_ROW       = 8;
  localparam int DEF_NUM_COL       = 8;
  localparam int DEF_K_DEPTH       = 8;
  localparam int DEF_FLUSH_TIMEOUT = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [2:0] feeder_state_t;

  localparam feeder_state_t ST_IDLE   = 3'd0;
  localparam feeder_state_t ST_CLEAR  = 3'd1;
  localparam feeder_state_t ST_STREAM = 3'd2;
  localparam feeder_state_t ST_FLUSH  = 3'd3;
  localparam feeder_state_t ST_DONE   = 3'd4;

  localparam int DEF_MAX_LANES = max_int(DEF_NUM_ROW, DEF_NUM_COL);
  localparam int DEF_ADDR_W    = width_for(DEF_K_DEPTH * DEF_MAX_LANES);
  localparam int DEF_BEAT_W    = width_for(DEF_K_DEPTH + DEF_MAX_LANES - 1);
  localparam int DEF_FLUSH_W   = width_for(DEF_FLUSH_TIMEOUT);

endpackage

// File: rtl/feeder_skew_line.sv
// rtl/feeder_skew_line.sv - DELAY-cycle shift register with synchronous clear for one operand lane
module feeder_skew_line #(
  parameter int DELAY = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_wire
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr};
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DELAY];
      logic [WIDTH-1:0] stage_d [DELAY];

      // Shift one stage per cycle; clear flushes every stage to zero.
      always_comb begin
        for (int i = 0; i < DELAY; i++) stage_d[i] = '0;
        if (!clr) begin
          stage_d[0] = din;
          for (int i = 1; i < DELAY; i++) stage_d[i] = stage_q[i-1];
        end
      end

      // Stage registers, zeroed by async reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand staging FSM feeding systolic_array; FEEDER_SKEW_EN adds per-lane diagonal skew
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int  IN_WORD_SIZE  = DEF_IN_WORD_SIZE,
  parameter int  NUM_ROW       = DEF_NUM_ROW,
  parameter int  NUM_COL       = DEF_NUM_COL,
  parameter int  K_DEPTH       = DEF_K_DEPTH,
  parameter int  FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT,
  localparam int MAX_LANES     = max_int(NUM_ROW, NUM_COL),
  localparam int ADDR_W        = width_for(K_DEPTH * MAX_LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic                            wr_sel,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [IN_WORD_SIZE-1:0]         wr_data,
  input  logic                            start,
  input  logic                            compute_done,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic                            arr_rst,
  output logic [IN_WORD_SIZE*NUM_ROW-1:0] left_inputs,
  output logic [IN_WORD_SIZE*NUM_COL-1:0] top_inputs
);

  localparam int LEFT_DEPTH = K_DEPTH * NUM_ROW;
  localparam int TOP_DEPTH  = K_DEPTH * NUM_COL;
  localparam int LEFT_IW    = width_for(LEFT_DEPTH);
  localparam int TOP_IW     = width_for(TOP_DEPTH);
`ifdef FEEDER_SKEW_EN
  // The tail lets the most-delayed lane drain its last beat before FLUSH.
  localparam int STREAM_LEN = K_DEPTH + MAX_LANES - 1;
`else
  localparam int STREAM_LEN = K_DEPTH;
`endif
  localparam int BEAT_W  = width_for(STREAM_LEN);
  localparam int FLUSH_W = width_for(FLUSH_TIMEOUT);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(STREAM_LEN - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_TIMEOUT - 1);

  logic [IN_WORD_SIZE-1:0] left_mem_q [LEFT_DEPTH];
  logic [IN_WORD_SIZE-1:0] top_mem_q  [TOP_DEPTH];
  logic                    left_we;
  logic                    top_we;

  feeder_state_t           state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [FLUSH_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic                    cd_seen_q, cd_seen_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic                    arr_rst_q, arr_rst_d;
  logic                    feed_en;
  logic [BEAT_W-1:0]       feed_beat;
  logic [LEFT_IW-1:0]      left_idx;
  logic [TOP_IW-1:0]       top_idx;
  logic [IN_WORD_SIZE*NUM_ROW-1:0] left_raw_q, left_raw_d;
  logic [IN_WORD_SIZE*NUM_COL-1:0] top_raw_q, top_raw_d;

  // Writes land only while idle and only inside the selected buffer.
  always_comb begin
    left_we = 1'b0;
    top_we  = 1'b0;
    if (wr_en && (state_q == ST_IDLE)) begin
      if (!wr_sel && (int'(wr_addr) < LEFT_DEPTH)) left_we = 1'b1;
      if (wr_sel && (int'(wr_addr) < TOP_DEPTH))   top_we  = 1'b1;
    end
  end

  // Operand storage has no reset so loaded matrices survive an aborted run.
  always_ff @(posedge clk) begin
    if (left_we) left_mem_q[LEFT_IW'(wr_addr)] <= wr_data;
    if (top_we)  top_mem_q[TOP_IW'(wr_addr)]   <= wr_data;
  end

  // Sequencer: CLEAR -> STREAM beats -> FLUSH until compute_done or expiry -> DONE pulse.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    flush_cnt_d = flush_cnt_q;
    cd_seen_d   = cd_seen_q;
    timeout_d   = 1'b0;
    feed_en     = 1'b0;
    feed_beat   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d   = ST_STREAM;
        beat_d    = '0;
        cd_seen_d = 1'b0;
        feed_en   = 1'b1;
      end
      ST_STREAM: begin
        // An early compute_done is remembered and honoured on the first FLUSH cycle.
        cd_seen_d = cd_seen_q | compute_done;
        if (beat_q == LAST_BEAT) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else begin
          beat_d    = beat_q + 1'b1;
          feed_en   = 1'b1;
          feed_beat = beat_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (compute_done || cd_seen_q) begin
          state_d = ST_DONE;
        end else if (flush_cnt_q == LAST_FLUSH) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        cd_seen_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    arr_rst_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
  end

  // Gather one beat across all lanes; skew-tail beats past K_DEPTH feed zeros.
  always_comb begin
    left_raw_d = '0;
    top_raw_d  = '0;
    left_idx   = '0;
    top_idx    = '0;
    if (feed_en && (int'(feed_beat) < K_DEPTH)) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        left_idx = LEFT_IW'(int'(feed_beat) * NUM_ROW + r);
        left_raw_d[r*IN_WORD_SIZE +: IN_WORD_SIZE] = left_mem_q[left_idx];
      end
      for (int c = 0; c < NUM_COL; c++) begin
        top_idx = TOP_IW'(int'(feed_beat) * NUM_COL + c);
        top_raw_d[c*IN_WORD_SIZE +: IN_WORD_SIZE] = top_mem_q[top_idx];
      end
    end
  end

  // Control state and registered outputs; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      flush_cnt_q <= '0;
      cd_seen_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      arr_rst_q   <= 1'b1;
      left_raw_q  <= '0;
      top_raw_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      flush_cnt_q <= flush_cnt_d;
      cd_seen_q   <= cd_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      arr_rst_q   <= arr_rst_d;
      left_raw_q  <= left_raw_d;
      top_raw_q   <= top_raw_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign arr_rst = arr_rst_q;

`ifdef FEEDER_SKEW_EN
  logic skew_clr;
  assign skew_clr = (state_q == ST_CLEAR);

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_left_skew
    feeder_skew_line #(.DELAY(r), .WIDTH(IN_WORD_SIZE)) u_line (
      .clk  (clk),
      .rst  (rst),
      .clr  (skew_clr),
      .din  (left_raw_q[r*IN_WORD_SIZE +: IN_WORD_SIZE]),
      .dout (left_inputs[r*IN_WORD_SIZE +: IN_WORD_SIZE])
    );
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_top_skew
    feeder_skew_line #(.DELAY(c), .WIDTH(IN_WORD_SIZE)) u_line (
      .clk  (clk),
      .rst  (rst),
      .clr  (skew_clr),
      .din  (top_raw_q[c*IN_WORD_SIZE +: IN_WORD_SIZE]),
      .dout (top_inputs[c*IN_WORD_SIZE +: IN_WORD_SIZE])
    );
  end
`else
  assign left_inputs = left_raw_q;
  assign top_inputs  = top_raw_q;
`endif

endmodule
